// File: rtl/sr_drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_drive_pkg
// Description : Shared types and constants for the SR flip-flop drive encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Excitation patterns, encoded {s, r}
    localparam logic [1:0] EXC_HOLD = 2'b00;
    localparam logic [1:0] EXC_SET  = 2'b10;
    localparam logic [1:0] EXC_RST  = 2'b01;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : sr_pulse_timer
// Description : Loadable down-counter; done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sr_drive_encoder.sv
`default_nettype none
// ============================================================================
// Module      : sr_drive_encoder
// Description : Turns target bit values into non-overlapping S/R pulses for a
//               downstream SR flop. Optional q_fb checking under the macro
//               SR_DRIVE_FEEDBACK_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_drive_encoder
    import sr_drive_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             q_model,
    output logic [CNT_W-1:0] pulse_cnt,
    input  logic             q_fb,
    output logic             err
);

    localparam int TMR_W = $clog2(max_int(PULSE_W, GAP_W)) + 1;

    state_e             state_q;
    logic               s_q;
    logic               r_q;
    logic               busy_q;
    logic               ready_q;
    logic               q_model_q;
    logic [CNT_W-1:0]   pulse_cnt_q;
    logic               err_q;

    logic               w_accept;
    logic               w_start;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_done;

    assign w_accept   = tgt_valid & ready_q;
    assign w_start    = w_accept & (tgt_bit != q_model_q);
    // Timer reloads on entry to DRIVE (pulse length) and on entry to GAP.
    assign w_tmr_load = ((state_q == IDLE) & w_start) |
                        ((state_q == DRIVE) & w_tmr_done);
    assign w_tmr_val  = (state_q == IDLE) ? TMR_W'(PULSE_W - 1) : TMR_W'(GAP_W - 1);

    sr_pulse_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .done_o     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            {s_q, r_q}  <= EXC_HOLD;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            q_model_q   <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_start) begin
                        state_q     <= DRIVE;
                        {s_q, r_q}  <= tgt_bit ? EXC_SET : EXC_RST;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
                    end else begin
                        ready_q     <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_tmr_done) begin
                        state_q    <= GAP;
                        {s_q, r_q} <= EXC_HOLD;
                        // s_q high means this pulse was a set
                        q_model_q  <= s_q;
                    end
                end
                GAP: begin
                    if (w_tmr_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    {s_q, r_q} <= EXC_HOLD;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRIVE_FEEDBACK_CHECK_EN
    logic w_fb_check;
    assign w_fb_check = (state_q == IDLE) | ((state_q == GAP) & w_tmr_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (w_fb_check && (q_fb != q_model_q)) begin
            err_q <= 1'b1;
        end
    end
`else
    logic w_unused_q_fb;
    assign w_unused_q_fb = q_fb;
    assign err_q         = 1'b0;
`endif

    assign tgt_ready = ready_q;
    assign s         = s_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign q_model   = q_model_q;
    assign pulse_cnt = pulse_cnt_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_drive_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_drive_encoder
// Description : Directed self-checking bench for sr_drive_encoder (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_drive_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        tgt_valid;
    logic        tgt_bit;
    logic        tgt_ready;
    logic        s;
    logic        r;
    logic        busy;
    logic        q_model;
    logic [15:0] pulse_cnt;
    logic        q_fb;
    logic        err;

    logic        flop_q;
    logic        stuck;
    int          checks   = 0;
    int          failures = 0;

`ifdef SR_DRIVE_FEEDBACK_CHECK_EN
    localparam logic c_ERR_EXP = 1'b1;
`else
    localparam logic c_ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    sr_drive_encoder #(
        .PULSE_W (2),
        .GAP_W   (1),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_bit   (tgt_bit),
        .tgt_ready (tgt_ready),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .q_model   (q_model),
        .pulse_cnt (pulse_cnt),
        .q_fb      (q_fb),
        .err       (err)
    );

    // Behavioural downstream SR flop; stuck forces its Q output low.
    always @(posedge clk or negedge reset) begin
        if (!reset)  flop_q <= 1'b0;
        else if (s)  flop_q <= 1'b1;
        else if (r)  flop_q <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : flop_q;

    always @(negedge clk) begin
        assert (!(s && r)) else begin
            failures++;
            $error("FAIL s_and_r observed=1 expected=0");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Offer one target for a single edge (caller knows tgt_ready is 1).
    task automatic offer(input logic b);
        tgt_valid = 1'b1;
        tgt_bit   = b;
        cyc();
        tgt_valid = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        int t[3];

        reset     = 1'b0;
        tgt_valid = 1'b0;
        tgt_bit   = 1'b0;
        stuck     = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", tgt_ready, 0);
        chk("rst_s",     s,         0);
        chk("rst_r",     r,         0);
        chk("rst_busy",  busy,      0);
        chk("rst_qm",    q_model,   0);
        chk("rst_cnt",   pulse_cnt, 0);
        chk("rst_err",   err,       0);
        reset = 1'b1;
        cyc();
        chk("ready_after_rst", tgt_ready, 1);

        // Set transition
        offer(1'b1);
        chk("set_c1_s", s, 1);
        chk("set_c1_r", r, 0);
        chk("set_c1_busy", busy, 1);
        chk("set_c1_ready", tgt_ready, 0);
        chk("set_c1_cnt", pulse_cnt, 1);
        cyc();
        chk("set_c2_s", s, 1);
        chk("set_c2_r", r, 0);
        chk("set_c2_qm", q_model, 0);
        cyc();
        chk("set_gap_s", s, 0);
        chk("set_gap_qm", q_model, 1);
        chk("set_gap_busy", busy, 1);
        chk("set_gap_ready", tgt_ready, 0);
        cyc();
        chk("set_idle_ready", tgt_ready, 1);
        chk("set_idle_busy", busy, 0);
        chk("set_idle_cnt", pulse_cnt, 1);

        // Reset transition
        offer(1'b0);
        chk("rst_c1_r", r, 1);
        chk("rst_c1_s", s, 0);
        cyc();
        chk("rst_c2_r", r, 1);
        cyc();
        chk("rst_gap_r", r, 0);
        chk("rst_gap_qm", q_model, 0);
        cyc();
        chk("rst_idle_ready", tgt_ready, 1);
        chk("rst_idle_cnt", pulse_cnt, 2);

        // Same-value targets: back-to-back accepts, no pulses
        tgt_valid = 1'b1;
        tgt_bit   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("same_ready", tgt_ready, 1);
            chk("same_sr", {s, r}, 0);
        end
        tgt_valid = 1'b0;
        chk("same_cnt", pulse_cnt, 2);

        // Held valid with alternating targets: accept spacing
        n         = 0;
        cnt       = 0;
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        while (n < 3 && cnt < 40) begin
            if (tgt_ready) begin
                t[n] = cnt;
                n++;
                cyc();
                cnt++;
                tgt_bit = ~tgt_bit;
                if (n == 3) tgt_valid = 1'b0;
            end else begin
                cyc();
                cnt++;
            end
        end
        tgt_valid = 1'b0;
        chk("alt_accepts", n, 3);
        chk("alt_gap01", t[1] - t[0], 4);
        chk("alt_gap12", t[2] - t[1], 4);
        cyc();
        cyc();
        cyc();
        chk("alt_qm", q_model, 1);
        chk("alt_ready", tgt_ready, 1);
        chk("alt_cnt", pulse_cnt, 5);

        // Reset during the second DRIVE cycle of an r pulse
        offer(1'b0);
        chk("mid_c1_r", r, 1);
        cyc();
        chk("mid_c2_r", r, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_s", s, 0);
        chk("mid_rst_r", r, 0);
        chk("mid_rst_qm", q_model, 0);
        chk("mid_rst_cnt", pulse_cnt, 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("mid_ready", tgt_ready, 1);
        offer(1'b1);
        chk("post_c1_s", s, 1);
        cyc();
        chk("post_c2_s", s, 1);
        chk("post_c2_r", r, 0);
        cyc();
        chk("post_gap_s", s, 0);
        chk("post_gap_qm", q_model, 1);
        cyc();
        chk("post_cnt", pulse_cnt, 1);
        chk("post_err", err, 0);

        // Feedback stuck low while driving a 1
        offer(1'b0);
        cyc();
        cyc();
        cyc();
        chk("fb_pre_ready", tgt_ready, 1);
        stuck = 1'b1;
        offer(1'b1);
        cyc();
        cyc();
        chk("fb_gap_err", err, 0);
        cyc();
        chk("fb_err_set", err, c_ERR_EXP);
        stuck = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("fb_err_sticky", err, c_ERR_EXP);
        reset = 1'b0;
        cyc();
        chk("fb_err_cleared", err, 0);
        reset = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sr_drive_encoder.md
Name: sr_drive_encoder

Overview:
- Drive side of the SR flip-flop interface: turns a stream of target bit values into legal S/R excitation pulses for a downstream SR flip-flop.
- Keeps a model of the flop's Q and pulses S or R only when the target differs from that model.
- Never asserts S and R together.
- Sits between a command source (valid/ready handshake) and the SR flop's s/r inputs.

Parameters:
- PULSE_W, 2, cycles S or R stays asserted per transition (≥1)
- GAP_W, 1, idle cycles after a pulse before the next target is accepted (≥1)
- CNT_W, 16, width of the pulse counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- tgt_valid  in  1  target bit offered
- tgt_bit  in  1  desired Q value
- tgt_ready  out  1  encoder accepts a target this cycle
- s  out  1  set excitation to the SR flop
- r  out  1  reset excitation to the SR flop
- busy  out  1  pulse or gap in progress
- q_model  out  1  encoder's model of the flop's Q
- pulse_cnt  out  CNT_W  number of S/R pulses issued, wraps
- q_fb  in  1  Q fed back from the flop (used only with the feature below)
- err  out  1  sticky feedback mismatch flag

Behaviour:
- All outputs are registered. Reset (reset=0) asynchronously forces:
  - state=IDLE, s=0, r=0, busy=0, q_model=0, pulse_cnt=0, err=0, tgt_ready=0
- tgt_ready rises on the first clk edge after reset deasserts.
- States:
  - IDLE: tgt_ready=1.
  - DRIVE: tgt_ready=0, busy=1, exactly one of s/r high.
  - GAP: tgt_ready=0, busy=1, s=r=0.
- Accept = tgt_valid & tgt_ready sampled at a rising edge.
- Accept with tgt_bit != q_model:
  - Next state DRIVE. s=tgt_bit and r=~tgt_bit, high for exactly PULSE_W cycles starting the cycle after the accept edge.
  - pulse_cnt increments once at entry.
- Accept with tgt_bit == q_model: no pulse, stays in IDLE, tgt_ready stays 1, so back-to-back accepts are allowed.
- DRIVE to GAP after PULSE_W cycles; q_model takes tgt_bit at that edge.
- GAP to IDLE after GAP_W cycles; tgt_ready is 1 again in the following cycle.
- Throughput: one transition per 1+PULSE_W+GAP_W cycles worst case.
- Invariant: s&r is never 1, including during reset entry and exit.
- tgt_valid high while tgt_ready=0 has no effect. The source must hold tgt_bit stable until accepted.
- pulse_cnt wraps from 2^CNT_W−1 to 0.
- Reset mid-DRIVE: s/r drop immediately and q_model returns to 0. The partially driven flop state is not tracked; the system resets the flop alongside.
- The internal cycle counter is sized $clog2(max(PULSE_W,GAP_W))+1 bits and reloads on each state entry.

Optional Feature:
- Macro: SR_DRIVE_FEEDBACK_CHECK_EN
- Defined:
  - On the last GAP cycle, q_fb is compared against q_model.
  - A mismatch sets err (sticky until reset).
  - Idle periods are also checked every cycle in IDLE; a mismatch there sets err.
- Undefined: q_fb is ignored and err is tied to 0.

Decomposition:
- Package sr_drive_pkg holds:
  - the state enum (IDLE, DRIVE, GAP)
  - the excitation constants (EXC_HOLD=2'b00, EXC_SET=2'b10, EXC_RST=2'b01), encoded {s,r}
- Sub-module sr_pulse_timer: loadable down-counter with a done flag, instantiated once and reused for both the DRIVE and GAP durations.

Test Plan:
- Reset, then tgt_bit=1 accepted at edge N:
  - s=1 for cycles N+1..N+2, r=0 throughout
  - q_model=1 at N+3, tgt_ready=1 at N+4, pulse_cnt=1
- From q_model=1, tgt_bit=0: r=1 for 2 cycles, s=0 throughout, q_model=0 afterwards, pulse_cnt=2.
- From q_model=0, tgt_bit=0 presented 5 consecutive cycles: 5 accepts, s=r=0, tgt_ready constantly 1, pulse_cnt unchanged.
- tgt_valid held high with tgt_bit alternating 1,0,1 each accept:
  - every accept is spaced exactly 4 cycles apart (defaults)
  - s&r==0 checked by assertion every cycle
- reset pulled low during the second DRIVE cycle: s, r and q_model are 0 in that same cycle; the first post-reset accept of tgt_bit=1 produces a full 2-cycle s pulse.
- With SR_DRIVE_FEEDBACK_CHECK_EN:
  - q_fb stuck at 0 while tgt_bit=1 is driven sets err=1 on the last GAP cycle, and err stays 1 until reset.
  - Without the macro, err=0 throughout the same stimulus.
